// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Registered WIDTH-bit ALU. It does add/sub/logic ops in a single cycle.
//   Multiply uses an iterative shift-add unit that consumes one multiplier bit
//   per cycle. The result and flags live in output registers. The block uses a
//   start/busy/done handshake.
//
// Ports
//   clk       rising-edge system clock
//   rst       asynchronous, active-high reset
//   start     issue request; sampled only while busy=0
//   A, B      WIDTH-bit operands, captured on an accepted start
//   code      opcode; code[2:0] selects the op, code[4:3] are ignored
//   busy      multiply in progress (start is ignored)
//   done      one-cycle pulse: Y and flags were updated this cycle
//   Y         registered result
//   carry, overflow, zero, negative
//             registered flags, updated together with Y
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_NOR  = 3'b111;

   typedef enum logic {IDLE, MUL} state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0]   a_reg, a_next;
   logic [WIDTH-1:0]   b_reg, b_next;
   logic               mulh_reg, mulh_next;
   logic [2*WIDTH-1:0] acc_reg, acc_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic [WIDTH-1:0]   y_reg, y_next;
   logic               carry_reg, carry_next;
   logic               overflow_reg, overflow_next;
   logic               zero_reg, zero_next;
   logic               negative_reg, negative_next;
   logic               done_reg, done_next;

   // MULL (010) and MULH (011) share code[2:1] = 01.
   logic is_mul_op;
   assign is_mul_op = (code[2:1] == 2'b01);

   // ---------------------------------------------------------------------------
   // Single-cycle datapath (operates directly on the live inputs)
   // ---------------------------------------------------------------------------
   logic               is_sub;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH-1:0]   alu_y;
   logic               alu_carry;
   logic               alu_overflow;

   assign is_sub  = (code[2:0] == OP_SUB);
   // Subtract is A + ~B + 1. The carry-out is then the "no borrow" indication.
   assign b_eff   = is_sub ? ~B : B;
   assign sum_ext = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

   always_comb begin
      alu_y        = '0;
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      case (code[2:0])
         OP_ADD, OP_SUB: begin
            alu_y        = sum_ext[WIDTH-1:0];
            alu_carry    = sum_ext[WIDTH];
            // Overflow occurs when both addends have the same sign and the
            // sum's sign differs from it. B is taken after any inversion.
            alu_overflow = (A[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum_ext[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  alu_y = A & B;
         OP_OR:   alu_y = A | B;
         OP_XOR:  alu_y = A ^ B;
         OP_NOR:  alu_y = ~(A | B);
         default: alu_y = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Shift-add multiplier. The table holds the gated partial product of each
   // multiplier bit. The counter selects the term to add this cycle.
   // ---------------------------------------------------------------------------
   logic [2*WIDTH-1:0] partial [WIDTH];
   logic [2*WIDTH-1:0] prod;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_partial
      assign partial[gi] = b_reg[gi] ? ({{WIDTH{1'b0}}, a_reg} << gi) : '0;
   end

   assign prod = acc_reg + partial[cnt_reg];

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // FSM: next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start && is_mul_op) state_next = MUL;
         MUL:     if (cnt_reg == CNT_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM: output and datapath-load logic
   always_comb begin
      a_next        = a_reg;
      b_next        = b_reg;
      mulh_next     = mulh_reg;
      acc_next      = acc_reg;
      cnt_next      = cnt_reg;
      y_next        = y_reg;
      carry_next    = carry_reg;
      overflow_next = overflow_reg;
      zero_next     = zero_reg;
      negative_next = negative_reg;
      done_next     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (is_mul_op) begin
                  a_next    = A;
                  b_next    = B;
                  mulh_next = code[0];
                  acc_next  = '0;
                  cnt_next  = '0;
               end else begin
                  done_next     = 1'b1;
                  y_next        = alu_y;
                  carry_next    = alu_carry;
                  overflow_next = alu_overflow;
                  zero_next     = (alu_y == '0);
                  negative_next = alu_y[WIDTH-1];
               end
            end
         end
         MUL: begin
            acc_next = prod;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST) begin
               done_next = 1'b1;
               if (mulh_reg) begin
                  y_next        = prod[2*WIDTH-1:WIDTH];
                  carry_next    = 1'b0;
                  overflow_next = 1'b0;
               end else begin
                  y_next        = prod[WIDTH-1:0];
                  carry_next    = |prod[2*WIDTH-1:WIDTH];
                  overflow_next = |prod[2*WIDTH-1:WIDTH];
               end
               zero_next     = (y_next == '0);
               negative_next = y_next[WIDTH-1];
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg        <= '0;
         b_reg        <= '0;
         mulh_reg     <= 1'b0;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         y_reg        <= '0;
         carry_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b0;
         negative_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         a_reg        <= a_next;
         b_reg        <= b_next;
         mulh_reg     <= mulh_next;
         acc_reg      <= acc_next;
         cnt_reg      <= cnt_next;
         y_reg        <= y_next;
         carry_reg    <= carry_next;
         overflow_reg <= overflow_next;
         zero_reg     <= zero_next;
         negative_reg <= negative_next;
         done_reg     <= done_next;
      end
   end

   assign busy     = (state_reg == MUL);
   assign done     = done_reg;
   assign Y        = y_reg;
   assign carry    = carry_reg;
   assign overflow = overflow_reg;
   assign zero     = zero_reg;
   assign negative = negative_reg;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Self-checking bench for seq_alu (WIDTH=8). It applies directed and random
//   operations and compares them with an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [4:0]   code;
   logic         busy;
   logic         done;
   logic [W-1:0] Y;
   logic         carry;
   logic         overflow;
   logic         zero;
   logic         negative;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [W-1:0] y;
      logic         c;
      logic         v;
      logic         z;
      logic         n;
   } res_t;

   res_t last_exp;

   seq_alu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .A        (A),
      .B        (B),
      .code     (code),
      .busy     (busy),
      .done     (done),
      .Y        (Y),
      .carry    (carry),
      .overflow (overflow),
      .zero     (zero),
      .negative (negative)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on the operand values.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [4:0] c);
      res_t   r;
      longint ua, ub, sa, sb, t;
      longint max_s, min_s, modv;
      ua    = longint'(a);
      ub    = longint'(b);
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      max_s = (longint'(1) << (W - 1)) - 1;
      min_s = -(longint'(1) << (W - 1));
      modv  = longint'(1) << W;
      r     = '0;
      case (c[2:0])
         3'd0: begin
            t   = ua + ub;
            r.y = W'(t);
            r.c = (t >= modv);
            t   = sa + sb;
            r.v = (t > max_s) || (t < min_s);
         end
         3'd1: begin
            t   = ua - ub;
            r.y = W'(t);
            r.c = (ua >= ub);
            t   = sa - sb;
            r.v = (t > max_s) || (t < min_s);
         end
         3'd2: begin
            t   = ua * ub;
            r.y = W'(t);
            r.c = (t >= modv);
            r.v = (t >= modv);
         end
         3'd3: begin
            t   = ua * ub;
            r.y = W'(t / modv);
         end
         3'd4: r.y = a & b;
         3'd5: r.y = a | b;
         3'd6: r.y = a ^ b;
         default: r.y = ~(a | b);
      endcase
      r.z = (r.y == '0);
      r.n = r.y[W-1];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outputs(input string tag, input res_t e);
      chk({tag, "_y"},   Y,        e.y);
      chk({tag, "_c"},   carry,    e.c);
      chk({tag, "_v"},   overflow, e.v);
      chk({tag, "_z"},   zero,     e.z);
      chk({tag, "_n"},   negative, e.n);
   endtask

   // Issue one operation and check its full result. For a multiply, the
   // operands, code and start are scrambled while busy to show they are ignored.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c);
      res_t e;
      e     = model(a, b, c);
      A     = a;
      B     = b;
      code  = c;
      start = 1'b1;
      step();
      start = 1'b0;
      if (c[2:1] == 2'b01) begin
         for (int i = 0; i < W; i++) begin
            chk("mul_busy", busy, 1'b1);
            chk("mul_done_early", done, 1'b0);
            start = 1'($urandom);
            A     = W'($urandom);
            B     = W'($urandom);
            code  = 5'($urandom);
            step();
         end
         start = 1'b0;
      end
      chk("op_done", done, 1'b1);
      chk("op_busy", busy, 1'b0);
      chk_outputs("op", e);
      last_exp = e;
      $display("op code=%b A=%02h B=%02h -> Y=%02h c=%0b v=%0b z=%0b n=%0b (exp Y=%02h)",
               c, a, b, Y, carry, overflow, zero, negative, e.y);
   endtask

   // Idle for one cycle. No done pulse should occur, and the outputs must hold.
   task automatic idle_hold();
      start = 1'b0;
      step();
      chk("hold_done", done, 1'b0);
      chk("hold_busy", busy, 1'b0);
      chk_outputs("hold", last_exp);
      $display("idle Y=%02h done=%0b", Y, done);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic [4:0]   rc;

      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      code  = '0;
      #3;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      last_exp = '0;
      chk_outputs("rst", last_exp);
      step();
      step();
      rst = 1'b0;
      step();
      chk("post_rst_done", done, 1'b0);
      chk_outputs("post_rst", last_exp);
      $display("reset released Y=%02h busy=%0b", Y, busy);

      // 1: signed overflow on ADD
      do_op(8'h7F, 8'h01, 5'b00000);
      chk("t1_y", Y, 8'h80);
      chk("t1_ovf", overflow, 1'b1);
      idle_hold();

      // 2: SUB to zero, then SUB with borrow
      do_op(8'h05, 8'h05, 5'b00001);
      chk("t2_zero", zero, 1'b1);
      chk("t2_carry", carry, 1'b1);
      do_op(8'h00, 8'h01, 5'b00001);
      chk("t2_y", Y, 8'hFF);
      chk("t2_carry_b", carry, 1'b0);

      // 3: MULL / MULH of 0xFF*0xFF
      do_op(8'hFF, 8'hFF, 5'b00010);
      chk("t3_mull", Y, 8'h01);
      // start accepted in the same cycle as done
      do_op(8'hFF, 8'hFF, 5'b00011);
      chk("t3_mulh", Y, 8'hFE);
      idle_hold();

      // 5: reset in the middle of a multiply
      A     = 8'h0F;
      B     = 8'h0F;
      code  = 5'b00010;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      last_exp = '0;
      chk_outputs("mid_rst", last_exp);
      #1 rst = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         step();
         chk("after_rst_done", done, 1'b0);
         chk("after_rst_busy", busy, 1'b0);
      end
      $display("mid-multiply reset: Y=%02h busy=%0b done=%0b", Y, busy, done);
      do_op(8'h02, 8'h03, 5'b00000);
      chk("t5_y", Y, 8'h05);

      // 6: back-to-back logic ops (reserved bits set on some)
      do_op(8'hF0, 8'h3C, 5'b00100);
      do_op(8'hF0, 8'h3C, 5'b01101);
      do_op(8'hF0, 8'h3C, 5'b10110);
      do_op(8'hF0, 8'h3C, 5'b11111);
      chk("t6_nor", Y, 8'h03);
      idle_hold();

      // Randomized operations
      for (int i = 0; i < 60; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
         rc = 5'($urandom);
         do_op(ra, rb, rc);
         if ($urandom_range(0, 3) == 0) idle_hold();
      end
      idle_hold();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
